// File: rtl/seq_wide_adder_pkg.sv
// Shared definitions for the sequential wide adder.
//   state_t   : FSM state encoding (IDLE, RUN, DONE).
//   cnt_width : chunk-counter width for a given chunk count, never below 1 bit.
package gf_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned num_chunks);
    return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
  endfunction

  // Counter width for the default configuration of four chunks.
  localparam int unsigned DEFAULT_CNT_W = cnt_width(4);

endpackage

// File: rtl/rca_adder.sv
// Narrow ripple-carry adder stage built from full_adder cells.
//   a, b : DATA_WIDTH-bit addends
//   ci   : carry into bit 0
//   sum  : DATA_WIDTH-bit sum
//   co   : carry out of the top bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module rca_adder #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  co
);
  logic [DATA_WIDTH:0] carry;

  assign carry[0] = ci;
  assign co       = carry[DATA_WIDTH];

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .ci  (carry[i]),
      .sum (sum[i]),
      .co  (carry[i+1])
    );
  end
endmodule

// File: rtl/seq_wide_adder.sv
// Multi-cycle wide adder/subtractor: one CHUNK_WIDTH-bit rca_adder is reused
// NUM_CHUNKS times, LSB chunk first, with the carry registered between cycles.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, ci, sub)
//   sub                 : 1 -> a - b (ci ignored), 0 -> a + b + ci
//   out_valid/out_ready : result handshake (sum, co)
//   sum, co             : W-bit result modulo 2^W; co = 1 means no borrow in sub
module seq_wide_adder
  import gf_adder_pkg::*;
#(
  parameter int unsigned CHUNK_WIDTH = 8,
  parameter int unsigned NUM_CHUNKS  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] a,
  input  logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] b,
  input  logic                              ci,
  input  logic                              sub,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHUNK_WIDTH*NUM_CHUNKS-1:0] sum,
  output logic                              co
);
  localparam int unsigned W     = CHUNK_WIDTH * NUM_CHUNKS;
  localparam int unsigned CNT_W = cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [W-1:0]       op_a, op_b;
  logic [CHUNK_WIDTH-1:0] add_a, add_b, add_sum;
  logic               add_co;

  // Chunk mux: select operand chunk [cnt] for the shared adder stage.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (cnt == CNT_W'(i)) begin
        add_a = op_a[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        add_b = op_b[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
  end

  rca_adder #(
    .DATA_WIDTH (CHUNK_WIDTH)
  ) u_rca (
    .a   (add_a),
    .b   (add_b),
    .ci  (carry),
    .sum (add_sum),
    .co  (add_co)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + 1: invert b here and seed the carry with 1.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : ci;
            cnt   <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
            if (cnt == CNT_W'(i)) sum[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= add_sum;
          end
          carry <= add_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) co <= add_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_wide_adder.sv
module tb_seq_wide_adder;
  localparam int unsigned CW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned W  = CW * NC;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b, sum;
  logic         ci, sub;
  logic         out_valid, out_ready, co;

  int checks = 0;
  int errors = 0;

  seq_wide_adder #(.CHUNK_WIDTH(CW), .NUM_CHUNKS(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the full width.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation; hold out_ready low for 'hold' cycles once done.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub, input int hold);
    logic [W:0]   exp;
    int           n;
    logic [W-1:0] s0;
    logic         c0;
    exp = model(ta, tb, tci, tsub);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = (hold == 0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NC));
    check({tag, "_sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, "_co"}, {63'd0, co}, {63'd0, exp[W]});
    if (hold > 0) begin
      s0 = sum; c0 = co;
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_bp_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_bp_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_bp_sum"}, 64'(sum), 64'(s0));
        check({tag, "_bp_co"}, {63'd0, co}, {63'd0, c0});
      end
      out_ready = 1'b1;
    end
    tick();
    check({tag, "_drain_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_drain_ready"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_held_sum"}, 64'(sum), 64'(exp[W-1:0]));
  endtask

  logic [W-1:0] qa [0:35];
  logic [W-1:0] qb [0:35];
  logic         qc [0:35];
  logic         qs [0:35];

  initial begin
    logic [W:0] exp;
    int         seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", {63'd0, co}, 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    run_op("carry_chunk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("ovf_b1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("ovf_ci", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
    run_op("sub_pos", 32'h1234_5678, 32'h0234_5678, 1'b0, 1'b1, 0);
    run_op("backpressure", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 6);

    // Reset two cycles into RUN.
    a = 32'hFFFF_FFFF; b = 32'h1; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_co", {63'd0, co}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    run_op("after_rst", 32'h0000_000A, 32'h0000_0014, 1'b0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      run_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    // Back-to-back with in_valid held high: accept at edges 0,6,12,...
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int e = 0; e < 36; e++) begin
      qa[e] = W'($urandom); qb[e] = W'($urandom);
      qc[e] = 1'($urandom); qs[e] = 1'($urandom);
      a = qa[e]; b = qb[e]; ci = qc[e]; sub = qs[e];
      tick();
      check("b2b_out_valid", {63'd0, out_valid}, {63'd0, (e % 6) == 4});
      check("b2b_in_ready", {63'd0, in_ready}, {63'd0, (e % 6) == 5});
      if ((e % 6) == 4) begin
        exp = model(qa[e-4], qb[e-4], qc[e-4], qs[e-4]);
        check("b2b_sum", 64'(sum), 64'(exp[W-1:0]));
        check("b2b_co", {63'd0, co}, {63'd0, exp[W]});
      end
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
